alu_exec: RTL and testbench

Execute stage between the register file read ports and its write port. It captures the two source operands, the opcode and the destination index on a start strobe. It then computes the result: single-cycle for add/sub/logic/pass, iterative for shift-left and 8×8 multiply. Finally it presents the result, destination and a one-cycle write-enable to the register file write port.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_iter_unit.sv | 63 ++++++
 rtl/alu_exec.sv | 149 ++++++++++++++
 tb/tb_alu_exec.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM encoding, flag layout
// and the flag packing helper used by the output registers.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_SHL   = 3'b101,
        OP_MUL   = 3'b110,
        OP_PASSB = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_N   = 2;
    localparam int FLAG_Z   = 1;
    localparam int FLAG_C   = 0;
    localparam int MUL_ITER = 8;

    function automatic logic [2:0] make_flags(input logic [7:0] res, input logic carry);
        logic [2:0] f;
        f         = 3'b000;
        f[FLAG_N] = res[7];
        f[FLAG_Z] = (res == 8'h00);
        f[FLAG_C] = carry;
        return f;
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath for SHL (one bit per step) and 8x8 shift-add multiply.
// res_o/carry_o show the value after the step taken on the coming edge.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_mul_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              last_o,
    output logic [DATA_W-1:0] res_o,
    output logic              carry_o
);

    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;
    logic [DATA_W-1:0]   mcand_q;
    logic [3:0]          cnt_q;
    logic [3:0]          target_q;
    logic                mul_q;
    logic [DATA_W:0]     sum_w;

    // MUL: multiplier sits in the low half and is consumed from bit 0 while the
    // partial product grows in the high half and shifts right each step.
    always_comb begin
        sum_w = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
              + (acc_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
        if (mul_q) begin
            acc_d   = {sum_w, acc_q[DATA_W-1:1]};
            carry_o = |acc_d[2*DATA_W-1:DATA_W];
        end else begin
            acc_d   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], 1'b0};
            carry_o = acc_q[DATA_W-1];
        end
        res_o  = acc_d[DATA_W-1:0];
        last_o = (cnt_q == target_q - 4'd1);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            mul_q    <= 1'b0;
        end else if (load_i) begin
            acc_q    <= is_mul_i ? {{DATA_W{1'b0}}, b_i} : {{DATA_W{1'b0}}, a_i};
            mcand_q  <= a_i;
            cnt_q    <= '0;
            target_q <= is_mul_i ? 4'(MUL_ITER) : {1'b0, b_i[2:0]};
            mul_q    <= is_mul_i;
        end else if (step_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: accepts an op in IDLE, finishes single-cycle ops at once and
// hands SHL/MUL to the iterative unit, then pulses done/we for one cycle.
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clka,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic [2:0]        op_in,
    input  logic [2:0]        rd_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              we_reg_out,
    output logic [2:0]        rd_out,
    output logic [DATA_W-1:0] result_out,
    output logic [2:0]        flags_out
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [2:0]        flags_q;
    logic [2:0]        rd_q, rd_d;
    logic [2:0]        rd_pend_q;
    logic              carry_d;
    logic              out_load;
    logic              iter_load;
    logic              iter_step;
    logic              is_mul;
    logic              needs_iter;
    logic              iter_last;
    logic [DATA_W-1:0] iter_res;
    logic              iter_carry;
    logic [DATA_W-1:0] sc_res;
    logic              sc_carry;
    logic [DATA_W:0]   wide_w;

    assign is_mul     = (op_in == OP_MUL);
    assign needs_iter = is_mul || ((op_in == OP_SHL) && (b_in[2:0] != 3'd0));

    // Single-cycle results; SHL here only covers the zero-count case.
    always_comb begin
        wide_w   = '0;
        sc_res   = '0;
        sc_carry = 1'b0;
        case (op_in)
            OP_ADD: begin
                wide_w   = {1'b0, a_in} + {1'b0, b_in};
                sc_res   = wide_w[DATA_W-1:0];
                sc_carry = wide_w[DATA_W];
            end
            OP_SUB: begin
                wide_w   = {1'b0, a_in} - {1'b0, b_in};
                sc_res   = wide_w[DATA_W-1:0];
                sc_carry = wide_w[DATA_W];
            end
            OP_AND:   sc_res = a_in & b_in;
            OP_OR:    sc_res = a_in | b_in;
            OP_XOR:   sc_res = a_in ^ b_in;
            OP_SHL:   sc_res = a_in;
            OP_PASSB: sc_res = b_in;
            default:  sc_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        out_load  = 1'b0;
        result_d  = result_q;
        carry_d   = 1'b0;
        rd_d      = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    if (needs_iter) begin
                        state_d   = ST_RUN;
                        iter_load = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        out_load = 1'b1;
                        result_d = sc_res;
                        carry_d  = sc_carry;
                        rd_d     = rd_in;
                    end
                end
            end
            ST_RUN: begin
                iter_step = 1'b1;
                if (iter_last) begin
                    state_d  = ST_DONE;
                    out_load = 1'b1;
                    result_d = iter_res;
                    carry_d  = iter_carry;
                    rd_d     = rd_pend_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            flags_q   <= '0;
            rd_q      <= '0;
            rd_pend_q <= '0;
        end else begin
            state_q <= state_d;
            if (iter_load) begin
                rd_pend_q <= rd_in;
            end
            if (out_load) begin
                result_q <= result_d;
                flags_q  <= make_flags(result_d, carry_d);
                rd_q     <= rd_d;
            end
        end
    end

    alu_iter_unit #(
        .DATA_W (DATA_W)
    ) u_iter (
        .clk_i    (clka),
        .srst_i   (reset_in),
        .load_i   (iter_load),
        .step_i   (iter_step),
        .is_mul_i (is_mul),
        .a_i      (a_in),
        .b_i      (b_in),
        .last_o   (iter_last),
        .res_o    (iter_res),
        .carry_o  (iter_carry)
    );

    assign busy_out   = (state_q != ST_IDLE);
    assign done_out   = (state_q == ST_DONE);
    assign we_reg_out = done_out;
    assign rd_out     = rd_q;
    assign result_out = result_q;
    assign flags_out  = flags_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed results, flags, latency and
// pulse counts per scenario.
module tb_alu_exec;
    import alu_pkg::*;

    logic       clka = 1'b0;
    logic       reset_in = 1'b0;
    logic       start_in = 1'b0;
    logic [2:0] op_in = 3'b000;
    logic [2:0] rd_in = 3'b000;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       busy_out, done_out, we_reg_out;
    logic [2:0] rd_out;
    logic [7:0] result_out;
    logic [2:0] flags_out;

    int checks = 0;
    int errors = 0;

    always #5 clka = ~clka;

    alu_exec #(.DATA_W(8)) dut (
        .clka       (clka),
        .reset_in   (reset_in),
        .start_in   (start_in),
        .op_in      (op_in),
        .rd_in      (rd_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .we_reg_out (we_reg_out),
        .rd_out     (rd_out),
        .result_out (result_out),
        .flags_out  (flags_out)
    );

    // Presents a start for exactly one edge; returns 1 time unit after it.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] rd);
        op_in = op; a_in = a; b_in = b; rd_in = rd; start_in = 1'b1;
        @(posedge clka); #1;
        start_in = 1'b0;
    endtask

    // Samples ncyc cycles starting right after the accepting edge (sample 1).
    task automatic watch(input int ncyc, input bit scramble, input bit inject,
                         output int lat, output int pulses, output int busy_cnt,
                         output int we_bad);
        lat = 0; pulses = 0; busy_cnt = 0; we_bad = 0;
        for (int i = 1; i <= ncyc; i++) begin
            if (i > 1) begin
                @(posedge clka); #1;
            end
            if (done_out === 1'b1) begin
                pulses++;
                if (lat == 0) lat = i;
            end
            if (busy_out === 1'b1) busy_cnt++;
            if (we_reg_out !== done_out) we_bad++;
            if (scramble) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
            if (inject && i == 3) begin
                start_in = 1'b1; op_in = OP_ADD; a_in = 8'h11; b_in = 8'h22; rd_in = 3'd1;
            end
            if (inject && i == 4) start_in = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        op_in = OP_ADD; a_in = 8'h01; b_in = 8'h01; rd_in = 3'd4; start_in = 1'b1;
        @(posedge clka); #1;
        @(posedge clka); #1;
        start_in = 1'b0;
        checks++;
        if ({busy_out, done_out, we_reg_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/we=%b required 000", {busy_out, done_out, we_reg_out});
        end
        checks++;
        if ({rd_out, result_out, flags_out} !== 14'd0) begin
            errors++;
            $display("FAIL reset_data: rd=%0d result=%h flags=%b required 0/00/000",
                     rd_out, result_out, flags_out);
        end
        reset_in = 1'b0;
        @(posedge clka); #1;
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_dropped: busy=%b done=%b required 0 0", busy_out, done_out);
        end
        $display("reset: busy=%b done=%b result=%h flags=%b", busy_out, done_out, result_out, flags_out);
    endtask

    // Single-cycle ops: table of {op, a, b, rd, result, flags}.
    task automatic test_single_cycle();
        logic [2:0] ops [9] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_PASSB, OP_AND};
        logic [7:0] av  [9] = '{8'hF0, 8'h7F, 8'h05, 8'h03, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h0F};
        logic [7:0] bv  [9] = '{8'h20, 8'h01, 8'h05, 8'h05, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'hF0};
        logic [2:0] rds [9] = '{3'd3, 3'd5, 3'd1, 3'd2, 3'd6, 3'd7, 3'd4, 3'd0, 3'd3};
        logic [7:0] er  [9] = '{8'h10, 8'h80, 8'h00, 8'hFE, 8'h42, 8'hDB, 8'h99, 8'h5A, 8'h00};
        logic [2:0] ef  [9] = '{3'b001, 3'b100, 3'b010, 3'b101, 3'b000, 3'b100, 3'b100, 3'b000, 3'b010};
        int lat, pulses, busy_cnt, we_bad;
        for (int k = 0; k < 9; k++) begin
            issue(ops[k], av[k], bv[k], rds[k]);
            watch(3, 1'b0, 1'b0, lat, pulses, busy_cnt, we_bad);
            checks++;
            if (result_out !== er[k] || flags_out !== ef[k] || rd_out !== rds[k]) begin
                errors++;
                $display("FAIL single_%0d: result=%h flags=%b rd=%0d required %h %b %0d",
                         k, result_out, flags_out, rd_out, er[k], ef[k], rds[k]);
            end
            checks++;
            if (lat != 1 || pulses != 1 || busy_cnt != 1 || we_bad != 0) begin
                errors++;
                $display("FAIL single_%0d_timing: lat=%0d pulses=%0d busy=%0d we_bad=%0d required 1 1 1 0",
                         k, lat, pulses, busy_cnt, we_bad);
            end
            $display("op=%0d a=%h b=%h -> result=%h flags=%b rd=%0d lat=%0d",
                     ops[k], av[k], bv[k], result_out, flags_out, rd_out, lat);
        end
    endtask

    task automatic test_shl();
        logic [7:0] av  [5] = '{8'h81, 8'h81, 8'h81, 8'h01, 8'h40};
        logic [7:0] bv  [5] = '{8'h01, 8'h00, 8'h07, 8'h03, 8'hF9};
        logic [7:0] er  [5] = '{8'h02, 8'h81, 8'h80, 8'h08, 8'h80};
        logic [2:0] ef  [5] = '{3'b001, 3'b100, 3'b100, 3'b000, 3'b100};
        int         el  [5] = '{2, 1, 8, 4, 2};
        int lat, pulses, busy_cnt, we_bad;
        for (int k = 0; k < 5; k++) begin
            issue(OP_SHL, av[k], bv[k], 3'(k + 1));
            watch(el[k] + 2, 1'b0, 1'b0, lat, pulses, busy_cnt, we_bad);
            checks++;
            if (result_out !== er[k] || flags_out !== ef[k] || rd_out !== 3'(k + 1)) begin
                errors++;
                $display("FAIL shl_%0d: result=%h flags=%b rd=%0d required %h %b %0d",
                         k, result_out, flags_out, rd_out, er[k], ef[k], k + 1);
            end
            checks++;
            if (lat != el[k] || pulses != 1 || busy_cnt != el[k] || we_bad != 0) begin
                errors++;
                $display("FAIL shl_%0d_timing: lat=%0d pulses=%0d busy=%0d we_bad=%0d required %0d 1 %0d 0",
                         k, lat, pulses, busy_cnt, we_bad, el[k], el[k]);
            end
            $display("SHL a=%h b=%h -> result=%h flags=%b lat=%0d", av[k], bv[k], result_out, flags_out, lat);
        end
    endtask

    task automatic test_mul();
        logic [7:0] av [3] = '{8'h13, 8'hFF, 8'h00};
        logic [7:0] bv [3] = '{8'h0E, 8'hFF, 8'h9C};
        logic [7:0] er [3] = '{8'h0A, 8'h01, 8'h00};
        logic [2:0] ef [3] = '{3'b001, 3'b001, 3'b010};
        int lat, pulses, busy_cnt, we_bad;
        for (int k = 0; k < 3; k++) begin
            issue(OP_MUL, av[k], bv[k], 3'd5);
            watch(14, 1'b0, k == 0, lat, pulses, busy_cnt, we_bad);
            checks++;
            if (result_out !== er[k] || flags_out !== ef[k] || rd_out !== 3'd5) begin
                errors++;
                $display("FAIL mul_%0d: result=%h flags=%b rd=%0d required %h %b 5",
                         k, result_out, flags_out, rd_out, er[k], ef[k]);
            end
            checks++;
            if (lat != 9 || pulses != 1 || busy_cnt != 9 || we_bad != 0) begin
                errors++;
                $display("FAIL mul_%0d_timing: lat=%0d pulses=%0d busy=%0d we_bad=%0d required 9 1 9 0",
                         k, lat, pulses, busy_cnt, we_bad);
            end
            $display("MUL a=%h b=%h -> result=%h flags=%b lat=%0d pulses=%0d",
                     av[k], bv[k], result_out, flags_out, lat, pulses);
        end
    endtask

    task automatic test_operand_change();
        int lat, pulses, busy_cnt, we_bad;
        issue(OP_MUL, 8'h0F, 8'h11, 3'd6);
        watch(12, 1'b1, 1'b0, lat, pulses, busy_cnt, we_bad);
        checks++;
        if (result_out !== 8'hFF || flags_out !== 3'b100 || rd_out !== 3'd6) begin
            errors++;
            $display("FAIL operand_hold: result=%h flags=%b rd=%0d required ff 100 6",
                     result_out, flags_out, rd_out);
        end
        checks++;
        if (lat != 9 || pulses != 1) begin
            errors++;
            $display("FAIL operand_hold_timing: lat=%0d pulses=%0d required 9 1", lat, pulses);
        end
        $display("MUL scrambled inputs -> result=%h flags=%b lat=%0d", result_out, flags_out, lat);
    endtask

    task automatic test_reset_mid_mul();
        int lat, pulses, busy_cnt, we_bad;
        issue(OP_MUL, 8'h13, 8'h0E, 3'd7);
        for (int i = 0; i < 3; i++) begin
            @(posedge clka); #1;
        end
        reset_in = 1'b1;
        @(posedge clka); #1;
        reset_in = 1'b0;
        checks++;
        if ({busy_out, done_out, we_reg_out} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_ctrl: busy/done/we=%b required 000", {busy_out, done_out, we_reg_out});
        end
        checks++;
        if (result_out !== 8'h00 || flags_out !== 3'b000 || rd_out !== 3'd0) begin
            errors++;
            $display("FAIL midreset_data: result=%h flags=%b rd=%0d required 00 000 0",
                     result_out, flags_out, rd_out);
        end
        watch(12, 1'b0, 1'b0, lat, pulses, busy_cnt, we_bad);
        checks++;
        if (pulses != 0 || busy_cnt != 0 || we_bad != 0) begin
            errors++;
            $display("FAIL midreset_quiet: pulses=%0d busy=%0d we_bad=%0d required 0 0 0",
                     pulses, busy_cnt, we_bad);
        end
        $display("MUL reset mid-run -> busy=%b result=%h flags=%b pulses=%0d",
                 busy_out, result_out, flags_out, pulses);
    endtask

    task automatic test_back_to_back();
        op_in = OP_ADD; a_in = 8'h01; b_in = 8'h02; rd_in = 3'd2; start_in = 1'b1;
        @(posedge clka); #1;
        op_in = OP_SUB; rd_in = 3'd3;
        checks++;
        if (done_out !== 1'b1 || result_out !== 8'h03 || flags_out !== 3'b000 || rd_out !== 3'd2) begin
            errors++;
            $display("FAIL b2b_first: done=%b result=%h flags=%b rd=%0d required 1 03 000 2",
                     done_out, result_out, flags_out, rd_out);
        end
        @(posedge clka); #1;
        checks++;
        if (done_out !== 1'b0 || busy_out !== 1'b0 || result_out !== 8'h03) begin
            errors++;
            $display("FAIL b2b_gap: done=%b busy=%b result=%h required 0 0 03",
                     done_out, busy_out, result_out);
        end
        @(posedge clka); #1;
        start_in = 1'b0;
        checks++;
        if (done_out !== 1'b1 || result_out !== 8'hFF || flags_out !== 3'b101 || rd_out !== 3'd3) begin
            errors++;
            $display("FAIL b2b_second: done=%b result=%h flags=%b rd=%0d required 1 ff 101 3",
                     done_out, result_out, flags_out, rd_out);
        end
        $display("back-to-back ADD then SUB -> result=%h flags=%b rd=%0d", result_out, flags_out, rd_out);
        @(posedge clka); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clka); #1;
        test_reset();
        test_single_cycle();
        test_shl();
        test_mul();
        test_operand_change();
        test_reset_mid_mul();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
